// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with instruction register and decoder.
// Drives the DR strobes and one-hot TDR enables, and muxes the TDR serial outputs onto TDO.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  NUM_TDR    = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001
) (
  input  logic                TCLK,
  input  logic                TRESET,
  input  logic                TMS,
  input  logic                TDI,
  input  logic [NUM_TDR-1:0]  TDR_SO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic [NUM_TDR-1:0]  TDR_EN,
  output logic [IR_WIDTH-1:0] IR_OUT
);

  localparam logic [3:0] TLR     = 4'h0;
  localparam logic [3:0] RTI     = 4'h1;
  localparam logic [3:0] SELDR   = 4'h2;
  localparam logic [3:0] CAPDR   = 4'h3;
  localparam logic [3:0] SHDR    = 4'h4;
  localparam logic [3:0] EX1DR   = 4'h5;
  localparam logic [3:0] PAUSEDR = 4'h6;
  localparam logic [3:0] EX2DR   = 4'h7;
  localparam logic [3:0] UPDDR   = 4'h8;
  localparam logic [3:0] SELIR   = 4'h9;
  localparam logic [3:0] CAPIR   = 4'hA;
  localparam logic [3:0] SHIR    = 4'hB;
  localparam logic [3:0] EX1IR   = 4'hC;
  localparam logic [3:0] PAUSEIR = 4'hD;
  localparam logic [3:0] EX2IR   = 4'hE;
  localparam logic [3:0] UPDIR   = 4'hF;

  logic [3:0]          tapState;
  logic [3:0]          nextState;
  logic [IR_WIDTH-1:0] irShift;
  logic [IR_WIDTH-1:0] irLatch;
  logic [IR_WIDTH-1:0] irLatchNext;
  logic                bypassBit;
  logic                bypassSel;

  // Opcodes at or above NUM_TDR decode to no enable, i.e. BYPASS.
  function automatic logic [NUM_TDR-1:0] decodeTdr(input logic [IR_WIDTH-1:0] op);
    logic [NUM_TDR-1:0] dec;
    dec = {NUM_TDR{1'b0}};
    for (int k = 0; k < NUM_TDR; k++) begin
      dec[k] = (op == IR_WIDTH'(k));
    end
    return dec;
  endfunction

  assign bypassSel = ~|TDR_EN;
  assign IR_OUT    = irLatch;

  // TAP state transition table
  always_comb begin
    nextState = tapState;
    case (tapState)
      TLR:     nextState = TMS ? TLR     : RTI;
      RTI:     nextState = TMS ? SELDR   : RTI;
      SELDR:   nextState = TMS ? SELIR   : CAPDR;
      CAPDR:   nextState = TMS ? EX1DR   : SHDR;
      SHDR:    nextState = TMS ? EX1DR   : SHDR;
      EX1DR:   nextState = TMS ? UPDDR   : PAUSEDR;
      PAUSEDR: nextState = TMS ? EX2DR   : PAUSEDR;
      EX2DR:   nextState = TMS ? UPDDR   : SHDR;
      UPDDR:   nextState = TMS ? SELDR   : RTI;
      SELIR:   nextState = TMS ? TLR     : CAPIR;
      CAPIR:   nextState = TMS ? EX1IR   : SHIR;
      SHIR:    nextState = TMS ? EX1IR   : SHIR;
      EX1IR:   nextState = TMS ? UPDIR   : PAUSEIR;
      PAUSEIR: nextState = TMS ? EX2IR   : PAUSEIR;
      EX2IR:   nextState = TMS ? UPDIR   : SHIR;
      UPDIR:   nextState = TMS ? SELDR   : RTI;
      default: nextState = TLR;
    endcase
  end

  // Instruction latch source for the coming falling edge
  always_comb begin
    irLatchNext = irLatch;
    if (tapState == UPDIR) begin
      irLatchNext = irShift;
    end else if (tapState == TLR) begin
      irLatchNext = {IR_WIDTH{1'b1}};
    end else begin
      irLatchNext = irLatch;
    end
  end

  // Rising edge: state, DR strobes (decoded from the next state so they track the state register), IR shift, bypass bit
  always_ff @(posedge TCLK or posedge TRESET) begin
    if (TRESET) begin
      tapState  <= TLR;
      CaptureDR <= 1'b0;
      ShiftDR   <= 1'b0;
      UpdateDR  <= 1'b0;
      irShift   <= {IR_WIDTH{1'b0}};
      bypassBit <= 1'b0;
    end else begin
      tapState  <= nextState;
      CaptureDR <= (nextState == CAPDR);
      ShiftDR   <= (nextState == SHDR);
      UpdateDR  <= (nextState == UPDDR);
      case (tapState)
        CAPIR:   irShift <= IR_CAPTURE;
        SHIR:    irShift <= {TDI, irShift[IR_WIDTH-1:1]};
        default: irShift <= irShift;
      endcase
      if (bypassSel) begin
        case (tapState)
          CAPDR:   bypassBit <= 1'b0;
          SHDR:    bypassBit <= TDI;
          default: bypassBit <= bypassBit;
        endcase
      end else begin
        bypassBit <= bypassBit;
      end
    end
  end

  // Falling edge: instruction latch with its decode, and the TDO output stage
  always_ff @(negedge TCLK or posedge TRESET) begin
    if (TRESET) begin
      irLatch <= {IR_WIDTH{1'b1}};
      TDR_EN  <= {NUM_TDR{1'b0}};
      TDO     <= 1'b0;
      TDO_EN  <= 1'b0;
    end else begin
      irLatch <= irLatchNext;
      TDR_EN  <= decodeTdr(irLatchNext);
      case (tapState)
        SHIR: begin
          TDO    <= irShift[0];
          TDO_EN <= 1'b1;
        end
        SHDR: begin
          TDO    <= bypassSel ? bypassBit : |(TDR_SO & TDR_EN);
          TDO_EN <= 1'b1;
        end
        default: begin
          TDO    <= TDO;
          TDO_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: expected TDO bits are queued at stimulus time
// and popped by a monitor whenever TDO_EN marks a valid output bit.
module tb_jtag_tap_ctrl;

  logic       TCLK   = 1'b0;
  logic       TRESET = 1'b0;
  logic       TMS    = 1'b0;
  logic       TDI    = 1'b0;
  logic [3:0] TDR_SO = 4'b0000;
  logic       TDO;
  logic       TDO_EN;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic [3:0] TDR_EN;
  logic [3:0] IR_OUT;

  int   checks   = 0;
  int   failures = 0;
  logic expQ[$];
  int   capCnt, shCnt, updCnt;

  jtag_tap_ctrl #(.IR_WIDTH(4), .NUM_TDR(4), .IR_CAPTURE(4'b0001)) dut (
    .TCLK(TCLK), .TRESET(TRESET), .TMS(TMS), .TDI(TDI), .TDR_SO(TDR_SO),
    .TDO(TDO), .TDO_EN(TDO_EN), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
    .UpdateDR(UpdateDR), .TDR_EN(TDR_EN), .IR_OUT(IR_OUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full TCLK period: drive, rising edge, falling edge, settle.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    #5 TCLK = 1'b1;
    #5 TCLK = 1'b0;
    #2;
  endtask

  task automatic chkStrobes(input string name, input logic [2:0] exp);
    chk(name, 32'({CaptureDR, ShiftDR, UpdateDR}), 32'(exp));
  endtask

  // From TLR or RTI, scan op into the IR and finish in RTI.
  task automatic loadIr(input logic [3:0] op, input logic [3:0] prevIr);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expQ.push_back(1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(1'b0);
      step(1'b0, op[i]);
    end
    step(1'b1, op[3]);
    chk("ir_hold_before_update", 32'(IR_OUT), 32'(prevIr));
    step(1'b1, 1'b0);
    chk("ir_update", 32'(IR_OUT), 32'(op));
    step(1'b0, 1'b0);
  endtask

  // Monitor: every valid TDO bit must match the next queued expectation.
  always @(negedge TCLK) begin
    #1;
    if (TDO_EN === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL tdo_unexpected actual=%b expected=no_output", TDO);
      end else begin
        logic e;
        e = expQ.pop_front();
        if (TDO !== e) begin
          failures++;
          $display("FAIL tdo_bit actual=%b expected=%b", TDO, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [3:0] so;

    // Reset with the clock stopped
    #2 TRESET = 1'b1;
    #3;
    chk("rst_ir_out", 32'(IR_OUT), 32'(4'hF));
    chk("rst_tdr_en", 32'(TDR_EN), 32'(4'h0));
    chk("rst_tdo", 32'(TDO), 32'(1'b0));
    chk("rst_tdo_en", 32'(TDO_EN), 32'(1'b0));
    chkStrobes("rst_strobes", 3'b000);
    TRESET = 1'b0;
    #3;

    // IR load of opcode 2
    loadIr(4'h2, 4'hF);
    chk("ir2_tdr_en", 32'(TDR_EN), 32'(4'b0100));

    // DR strobes with TDR 2 selected
    capCnt = 0; shCnt = 0; updCnt = 0;
    step(1'b1, 1'b0);
    chkStrobes("selDR_strobes", 3'b000);
    step(1'b0, 1'b0);
    chkStrobes("capDR_strobes", 3'b100);
    capCnt += int'(CaptureDR); shCnt += int'(ShiftDR); updCnt += int'(UpdateDR);
    for (int i = 0; i < 33; i++) begin
      so = 4'($urandom);
      TDR_SO = so;
      expQ.push_back(so[2]);
      step(1'b0, 1'b0);
      chkStrobes("shDR_strobes", 3'b010);
      capCnt += int'(CaptureDR); shCnt += int'(ShiftDR); updCnt += int'(UpdateDR);
    end
    step(1'b1, 1'b0);
    chkStrobes("ex1DR_strobes", 3'b000);
    capCnt += int'(CaptureDR); shCnt += int'(ShiftDR); updCnt += int'(UpdateDR);
    step(1'b1, 1'b0);
    chkStrobes("updDR_strobes", 3'b001);
    capCnt += int'(CaptureDR); shCnt += int'(ShiftDR); updCnt += int'(UpdateDR);
    step(1'b0, 1'b0);
    chkStrobes("rti_strobes", 3'b000);
    chk("capture_cycles", 32'(capCnt), 32'd1);
    chk("shift_cycles", 32'(shCnt), 32'd33);
    chk("update_cycles", 32'(updCnt), 32'd1);
    chk("ir_stable_dr", 32'(IR_OUT), 32'(4'h2));

    // Five TMS=1 edges from Shift-DR reach TLR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    so = 4'($urandom);
    TDR_SO = so;
    expQ.push_back(so[2]);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tms_reset_ir", 32'(IR_OUT), 32'(4'hF));
    chk("tms_reset_tdr_en", 32'(TDR_EN), 32'(4'h0));
    chkStrobes("tms_reset_strobes", 3'b000);

    // Bypass: pattern 1,0,1,1 comes out as 0,1,0,1
    TDR_SO = 4'b1111;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expQ.push_back(1'b0); step(1'b0, 1'b0);
    expQ.push_back(1'b1); step(1'b0, 1'b1);
    expQ.push_back(1'b0); step(1'b0, 1'b0);
    expQ.push_back(1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("bypass_tdr_en", 32'(TDR_EN), 32'(4'h0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // IR scan interrupted by Pause-IR, opcode 5 (out of range -> bypass)
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expQ.push_back(1'b1); step(1'b0, 1'b0);
    expQ.push_back(1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("pause_tdo_en", 32'(TDO_EN), 32'(1'b0));
    end
    step(1'b1, 1'b0);
    expQ.push_back(1'b0); step(1'b0, 1'b0);
    expQ.push_back(1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pause_ir_out", 32'(IR_OUT), 32'(4'h5));
    chk("pause_tdr_en", 32'(TDR_EN), 32'(4'h0));
    step(1'b0, 1'b0);

    // Reset in the middle of an IR scan
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expQ.push_back(1'b1); step(1'b0, 1'b0);
    expQ.push_back(1'b0); step(1'b0, 1'b1);
    expQ.push_back(1'b0); step(1'b0, 1'b1);
    TRESET = 1'b1;
    #2;
    chk("midrst_ir_out", 32'(IR_OUT), 32'(4'hF));
    chk("midrst_tdo", 32'(TDO), 32'(1'b0));
    chk("midrst_tdo_en", 32'(TDO_EN), 32'(1'b0));
    chk("midrst_tdr_en", 32'(TDR_EN), 32'(4'h0));
    TRESET = 1'b0;
    #2;
    step(1'b1, 1'b0);
    chk("midrst_no_update", 32'(IR_OUT), 32'(4'hF));
    loadIr(4'h2, 4'hF);
    chk("rescan_tdr_en", 32'(TDR_EN), 32'(4'b0100));

    step(1'b0, 1'b0);
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller, instruction register and instruction decoder.
- Sits directly upstream of the gasket test data registers.
- Drives their CaptureDR/ShiftDR/UpdateDR strobes and one-hot Enable lines.
- Muxes their serial outputs, plus an internal bypass bit, onto TDO.

Parameters:
- IR_WIDTH, 4: instruction register length in bits.
- NUM_TDR, 4: number of attached TDRs. Must satisfy NUM_TDR < 2**IR_WIDTH.
- IR_CAPTURE, 'b0001: value loaded into the IR shift stage in Capture-IR. LSBs must be 01.

Ports:
- TCLK  in  1  test clock; single clock domain, both edges used.
- TRESET  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on posedge TCLK.
- TDI  in  1  serial data in.
- TDR_SO  in  NUM_TDR  serial outputs of the attached TDRs; bit k comes from TDR k.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while TDO carries valid shift data.
- CaptureDR  out  1  high in state Capture-DR.
- ShiftDR  out  1  high in state Shift-DR.
- UpdateDR  out  1  high in state Update-DR.
- TDR_EN  out  NUM_TDR  one-hot Enable for the TDRs; all zero when BYPASS is selected.
- IR_OUT  out  IR_WIDTH  current latched instruction.

Behaviour:
- Reset: TRESET=1 asynchronously forces the following values:
  - state=TLR, IR latch=all ones (BYPASS), IR shift stage=0, bypass bit=0.
  - TDO=0, TDO_EN=0.
  - Consequently TDR_EN=0 and CaptureDR/ShiftDR/UpdateDR=0.
  - Reset asserted mid-scan aborts the scan; no partial IR update occurs.
- State register: 16 states, advanced on posedge TCLK. Transitions are listed as next state for TMS=0 / TMS=1.
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - The IR branch (CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR) mirrors the DR branch exactly.
  - Five consecutive posedges with TMS=1 reach TLR from any state.
- DR strobes: CaptureDR, ShiftDR and UpdateDR are Moore decodes of the current state, with no extra latency.
  - A TDR therefore captures/shifts on the posedge that leaves the state.
  - A TDR updates on the negedge within UpdDR.
- IR shift stage (IR_WIDTH bits), posedge TCLK:
  - CapIR: load IR_CAPTURE.
  - ShIR: load {TDI, ir_shift[IR_WIDTH-1:1]} (LSB shifted out first).
  - Any other state: hold.
- IR latch, negedge TCLK:
  - In UpdIR: load the shift stage.
  - In TLR: load all ones.
  - Otherwise: hold.
  - The latch is stable for the whole DR scan.
- Decode:
  - Opcode k < NUM_TDR sets TDR_EN[k]=1, all other bits 0.
  - Any other opcode (including all ones) selects BYPASS, with TDR_EN=0.
- Bypass bit, posedge TCLK, active only when BYPASS is selected:
  - CapDR: clear to 0.
  - ShDR: load TDI.
  - Otherwise: hold.
- TDO, negedge TCLK:
  - In ShIR: TDO=ir_shift[0], TDO_EN=1.
  - In ShDR: TDO=TDR_SO[k] for the selected TDR (or the bypass bit under BYPASS), TDO_EN=1.
  - In any other state: TDO holds its last value, TDO_EN=0.
- Pause states: hold all shift contents. Exit2 then re-entering Shift continues the scan without loss.

Test Plan:
- Reset: pulse TRESET with TCLK stopped -> state TLR, IR_OUT=4'hF, TDR_EN=0, TDO=0, TDO_EN=0. From ShDR, clock 5 posedges with TMS=1 -> TLR and IR_OUT=4'hF.
- IR load: path TLR→RTI→SelDR→SelIR→CapIR, shift TDI bits 0,1,0,0 (LSB first) in ShIR, then UpdIR -> IR_OUT=4'h2 after the UpdIR negedge. TDR_EN=4'b0100. TDO across the 4 shift negedges = 1,0,0,0 (IR_CAPTURE).
- DR strobes: with opcode 2, walk CapDR→ShDR×33→Ex1DR→UpdDR -> the following hold, and each other strobe stays low:
  - CaptureDR high for exactly 1 cycle.
  - ShiftDR high for 33 cycles.
  - UpdateDR high for 1 cycle.
  - TDO mirrors TDR_SO[2] on each Shift-DR negedge.
- Bypass: IR=4'hF, shift TDI pattern 1,0,1,1 through ShDR -> TDO emits 0 (the captured bypass bit), then 1,0,1, delayed one cycle. TDR_EN=0.
- Pause: shift 2 IR bits, go Ex1IR→PauseIR×3→Ex2IR→ShIR, shift 2 more bits, then UpdIR -> IR_OUT equals the uninterrupted 4-bit result. TDO_EN=0 during the pause.
- Reset mid-scan: assert TRESET during ShIR after 2 bits -> immediate TLR, IR_OUT=4'hF, no UpdIR effect. After release, a fresh scan behaves as in the IR-load scenario.
